// File: rtl/core_pkg.sv
// Shared encodings for the core sequencer: instruction types, RV32I opcodes, branch fun3 codes, FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package core_pkg;

    // Instruction type codes presented on instType
    localparam logic [3:0] IT_LOAD   = 4'd0;
    localparam logic [3:0] IT_IMM    = 4'd1;
    localparam logic [3:0] IT_STORE  = 4'd2;
    localparam logic [3:0] IT_REG    = 4'd3;
    localparam logic [3:0] IT_LUI    = 4'd4;
    localparam logic [3:0] IT_AUIPC  = 4'd5;
    localparam logic [3:0] IT_BRANCH = 4'd6;
    localparam logic [3:0] IT_JALR   = 4'd7;
    localparam logic [3:0] IT_JAL    = 4'd8;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Branch condition codes (fun3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_t;

    // 010/011 have no branch meaning and are rejected at decode
    function automatic logic branch_fun3_ok(input logic [2:0] f3);
        return !((f3 == 3'b010) || (f3 == 3'b011));
    endfunction

    // flags = {Z, C, N, V}; unsigned compares follow the unit's borrow-style carry
    function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] flags);
        logic z, c, n, v;
        z = flags[3];
        c = flags[2];
        n = flags[1];
        v = flags[0];
        case (f3)
            F3_BEQ:  return z;
            F3_BNE:  return !z;
            F3_BLT:  return n ^ v;
            F3_BGE:  return !(n ^ v);
            F3_BLTU: return !c;
            F3_BGEU: return c;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extractor: sign-extended I/S/B/U/J immediate selected by format.
// Latency: purely combinational.
// Backpressure: none.
module imm_gen
    import core_pkg::*;
(
    input  logic [31:7] instr,   // opcode bits never contribute to the immediate
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    // Reassemble the scattered immediate fields for the selected format
    always_comb begin
        imm = 32'd0;
        case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'd0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, hold datapath for EXEC_CYCLES, update pc. Optional ILLEGAL_TRAP_EN.
// Latency: fetch wait + 1 + EXEC_CYCLES + 1 cycles per instruction (5 at zero-wait memory, default EXEC_CYCLES).
// Backpressure: FETCH holds imem_req until imem_valid; imem_valid is ignored in every other state.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned EXEC_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] rs1_data,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  instType,
    output logic [2:0]  fun3,
    output logic        fun7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] pc,
    output logic [31:0] imm,
    output logic        instr_done,
    output logic [31:0] instret,
    output logic        illegal
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] instr_q;
    logic [3:0]  cnt;
    logic [3:0]  d_type;
    imm_fmt_t    d_fmt;
    logic        d_bad;
    logic [31:0] d_imm;
    logic [31:0] pc_nxt;

    imm_gen u_imm_gen (
        .instr (instr_q[31:7]),
        .fmt   (d_fmt),
        .imm   (d_imm)
    );

    // Classify the latched word: type code, immediate format, and whether it is unrecognised
    always_comb begin
        d_type = IT_IMM;
        d_fmt  = FMT_NONE;
        d_bad  = 1'b0;
        case (instr_q[6:0])
            OPC_LOAD:   begin d_type = IT_LOAD;   d_fmt = FMT_I; end
            OPC_IMM:    begin d_type = IT_IMM;    d_fmt = FMT_I; end
            OPC_STORE:  begin d_type = IT_STORE;  d_fmt = FMT_S; end
            OPC_REG:    begin d_type = IT_REG;    d_fmt = FMT_NONE; end
            OPC_LUI:    begin d_type = IT_LUI;    d_fmt = FMT_U; end
            OPC_AUIPC:  begin d_type = IT_AUIPC;  d_fmt = FMT_U; end
            OPC_BRANCH: begin
                d_type = IT_BRANCH;
                d_fmt  = FMT_B;
                d_bad  = !branch_fun3_ok(instr_q[14:12]);
            end
            OPC_JALR:   begin d_type = IT_JALR;   d_fmt = FMT_I; end
            OPC_JAL:    begin d_type = IT_JAL;    d_fmt = FMT_J; end
            default:    d_bad = 1'b1;
        endcase
    end

    // Next pc from the decoded (held-stable) control outputs; plain 32-bit wrap
    always_comb begin
        pc_nxt = pc + 32'd4;
        case (instType)
            IT_JAL:    pc_nxt = pc + imm;
            IT_BRANCH: pc_nxt = branch_taken(fun3, alu_flags) ? (pc + imm) : (pc + 32'd4);
            IT_JALR:   pc_nxt = (rs1_data + imm) & ~32'd1;
            default:   pc_nxt = pc + 32'd4;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  state_nxt = imem_valid ? ST_DECODE : ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_DECODE: state_nxt = d_bad ? ST_HALT : ST_EXEC;
            ST_HALT:   state_nxt = ST_HALT;
`else
            ST_DECODE: state_nxt = ST_EXEC;
`endif
            ST_EXEC:   state_nxt = (cnt == 4'd0) ? ST_UPDATE : ST_EXEC;
            ST_UPDATE: state_nxt = ST_FETCH;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    // Moore outputs: fetch request and retire pulse
    always_comb begin
        imem_req   = (state == ST_FETCH);
        instr_done = (state == ST_UPDATE);
    end

    assign imem_addr = pc;

    // Instruction latch, decoded control outputs, exec counter, pc and retire counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q  <= 32'd0;
            instType <= 4'd0;
            fun3     <= 3'd0;
            fun7     <= 1'b0;
            rd       <= 5'd0;
            rs1      <= 5'd0;
            rs2      <= 5'd0;
            imm      <= 32'd0;
            cnt      <= 4'd0;
            pc       <= RESET_PC;
            instret  <= 32'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr_q <= imem_rdata;
                    end
                end
                ST_DECODE: begin
                    cnt <= EXEC_LOAD;
                    if (d_bad) begin
                        // Unrecognised word degrades to addi x0,x0,0
                        instType <= IT_IMM;
                        fun3     <= 3'd0;
                        fun7     <= 1'b0;
                        rd       <= 5'd0;
                        rs1      <= 5'd0;
                        rs2      <= 5'd0;
                        imm      <= 32'd0;
                    end else begin
                        instType <= d_type;
                        fun3     <= instr_q[14:12];
                        fun7     <= instr_q[30];
                        rd       <= instr_q[11:7];
                        rs1      <= instr_q[19:15];
                        rs2      <= instr_q[24:20];
                        imm      <= d_imm;
                    end
                end
                ST_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_UPDATE: begin
                    pc      <= pc_nxt;
                    instret <= instret + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag, raised when a bad word leaves DECODE; cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
        end else if (state == ST_DECODE && d_bad) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed instructions push expected retire records, a monitor checks them.
// Latency: checks retire cycle against issue cycle + fetch wait + 5.
// Backpressure: exercises a 7-cycle fetch stall.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [3:0]  alu_flags = 4'd0;
    logic [3:0]  instType;
    logic [2:0]  fun3;
    logic        fun7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        instr_done;
    logic [31:0] instret;
    logic        illegal;

    core_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .EXEC_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .rs1_data   (rs1_data),
        .alu_flags  (alu_flags),
        .instType   (instType),
        .fun3       (fun3),
        .fun7       (fun7),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .pc         (pc),
        .imm        (imm),
        .instr_done (instr_done),
        .instret    (instret),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0]  it;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] ret;
        logic [31:0] done_cyc;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic [31:0] model_pc  = 32'd0;
    logic [31:0] model_ret = 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one instruction at the current FETCH (called just after a negedge)
    task automatic issue(input string nm, input logic [31:0] word, input logic [3:0] flags,
                         input logic [31:0] rs1v, input int waitc, input logic [3:0] eit,
                         input logic [4:0] erd, input logic [31:0] eimm, input logic [31:0] enext);
        exp_t e;
        int   n;
        imem_rdata = word;
        alu_flags  = flags;
        rs1_data   = rs1v;
        imem_valid = 1'b0;
        for (int i = 0; i < waitc; i++) begin
            @(negedge clk);
            check({nm, "_stall_req"}, imem_req, 1);
            check({nm, "_stall_pc"}, pc, model_pc);
            check({nm, "_stall_nodone"}, instr_done, 0);
        end
        e.it       = eit;
        e.rd       = erd;
        e.imm      = eimm;
        e.pc       = model_pc;
        e.pc_next  = enext;
        e.ret      = model_ret;
        e.done_cyc = cyc + 5;
        sb_q.push_back(e);
        name_q.push_back(nm);
        imem_valid = 1'b1;
        @(negedge clk);
        // Garbage offered while not fetching must be ignored
        imem_rdata = 32'hFFFF_FFFF;
        n = 0;
        while (!instr_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!instr_done) check({nm, "_retire_timeout"}, instr_done, 1);
        imem_valid = 1'b0;
        @(negedge clk);
        model_pc  = enext;
        model_ret = model_ret + 32'd1;
    endtask

    // Monitor: pop and compare on every retire pulse
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (rst && instr_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_retire", sb_q.size(), 1);
                end else begin
                    e  = sb_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, "_type"}, instType, e.it);
                    check({nm, "_rd"}, rd, e.rd);
                    check({nm, "_imm"}, imm, e.imm);
                    check({nm, "_pc"}, pc, e.pc);
                    check({nm, "_instret_pre"}, instret, e.ret);
                    check({nm, "_done_cycle"}, cyc, e.done_cyc);
                    @(negedge clk);
                    check({nm, "_pc_next"}, pc, e.pc_next);
                    check({nm, "_instret_post"}, instret, e.ret + 32'd1);
                    check({nm, "_done_pulse"}, instr_done, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, expected completion", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req", imem_req, 1);
        check("rst_pc", pc, 32'h0);
        check("rst_type", instType, 0);
        check("rst_rd", rd, 0);
        check("rst_imm", imm, 0);
        check("rst_instret", instret, 0);
        check("rst_done", instr_done, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b1;

        issue("addi",   32'h0050_0093, 4'b0000, 32'h0,      0, 4'd1, 5'd1,  32'd5,         32'h0000_0004);
        issue("lui",    32'h1234_52B7, 4'b0000, 32'h0,      0, 4'd4, 5'd5,  32'h1234_5000, 32'h0000_0008);
        issue("sw",     32'hFE20_AE23, 4'b0000, 32'h0,      0, 4'd2, 5'd28, 32'hFFFF_FFFC, 32'h0000_000C);
        issue("add",    32'h0020_81B3, 4'b0000, 32'h0,      0, 4'd3, 5'd3,  32'd0,         32'h0000_0010);
        issue("beq_t",  32'h0000_0463, 4'b1000, 32'h0,      0, 4'd6, 5'd8,  32'd8,         32'h0000_0018);
        issue("jal",    32'hFF9F_F06F, 4'b0000, 32'h0,      0, 4'd8, 5'd0,  32'hFFFF_FFF8, 32'h0000_0010);
        issue("beq_nt", 32'h0000_0463, 4'b0000, 32'h0,      0, 4'd6, 5'd8,  32'd8,         32'h0000_0014);
        issue("jalr",   32'h0041_00E7, 4'b0000, 32'h1003,   0, 4'd7, 5'd1,  32'd4,         32'h0000_1006);
        issue("auipc",  32'hFFFF_F397, 4'b0000, 32'h0,      7, 4'd5, 5'd7,  32'hFFFF_F000, 32'h0000_100A);
        issue("blt_t",  32'h0000_4863, 4'b0010, 32'h0,      0, 4'd6, 5'd16, 32'd16,        32'h0000_101A);
`ifndef ILLEGAL_TRAP_EN
        issue("bad_op", 32'h0000_007F, 4'b0000, 32'h0,      0, 4'd1, 5'd0,  32'd0,         32'h0000_101E);
        issue("bad_br", 32'h0000_2063, 4'b1000, 32'h0,      0, 4'd1, 5'd0,  32'd0,         32'h0000_1022);
        check("nop_illegal_low", illegal, 0);
`endif

        // Reset in the middle of EXEC abandons the instruction
        imem_rdata = 32'h0050_0093;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_type", instType, 0);
        check("mid_rst_rd", rd, 0);
        check("mid_rst_imm", imm, 0);
        check("mid_rst_instret", instret, 0);
        check("mid_rst_done", instr_done, 0);
        check("mid_rst_req", imem_req, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_pc  = 32'h0;
        model_ret = 32'h0;
        issue("addi_rst", 32'h0050_0093, 4'b0000, 32'h0, 0, 4'd1, 5'd1, 32'd5, 32'h0000_0004);

`ifdef ILLEGAL_TRAP_EN
        // Trap build: bad opcode halts without retiring
        imem_rdata = 32'h0000_007F;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        check("trap_illegal", illegal, 1);
        check("trap_req", imem_req, 0);
        imem_valid = 1'b1;
        repeat (8) @(negedge clk);
        check("trap_instret", instret, model_ret);
        check("trap_pc", pc, model_pc);
        check("trap_req_hold", imem_req, 0);
        check("trap_illegal_hold", illegal, 1);
        imem_valid = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter EXEC_CYCLES, default 3, datapath cycles held per instruction (range 1-15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch byte address (= pc).
REQ-007 imem_valid  input  1  imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 rs1_data  input  32  rs1 register value, used for jalr target.
REQ-010 alu_flags  input  4  ZCNV flags from function unit, bit3=Z, bit2=C, bit1=N, bit0=V.
REQ-011 instType  output  4  0 load, 1 imm, 2 store, 3 reg, 4 lui, 5 auipc, 6 branch, 7 jalr, 8 jal.
REQ-012 fun3  output  3;  fun7  output  1 (instr[30]);  rd, rs1, rs2  output  5 each.
REQ-013 pc  output  32;  imm  output  32 sign-extended immediate.
REQ-014 instr_done  output  1  one-cycle pulse per retired instruction.
REQ-015 instret  output  32  retired-instruction counter.
REQ-016 illegal  output  1  sticky illegal-opcode indication (see Configuration).

Function
REQ-017 SHALL implement states FETCH, DECODE, EXEC, UPDATE (plus HALT when ILLEGAL_TRAP_EN defined).
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_valid latch instruction, go DECODE; otherwise stay, holding request.
REQ-019 DECODE (1 cycle): register instType, fun3, fun7, rd, rs1, rs2, imm from latched word; load exec counter with EXEC_CYCLES-1.
REQ-020 Immediate formats: I for load/imm/jalr, S for store, B for branch, U for lui/auipc, J for jal; shift-immediate uses I format unchanged.
REQ-021 Control outputs SHALL remain stable from DECODE exit through UPDATE.
REQ-022 EXEC: decrement counter each cycle; at zero go UPDATE; total EXEC dwell exactly EXEC_CYCLES cycles.
REQ-023 UPDATE (1 cycle): compute next pc, pulse instr_done, increment instret, go FETCH.
REQ-024 Next pc: jal and taken branch pc+imm; jalr (rs1_data+imm) & ~1; all others pc+4; 32-bit wrap-around, no overflow detection.
REQ-025 Branch taken per fun3: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C; 010/011 treated as illegal.
REQ-026 instret SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 Instruction latency SHALL be (fetch wait)+1+EXEC_CYCLES+1 cycles; 5 cycles with zero-wait memory at default.
REQ-028 imem_valid outside FETCH SHALL be ignored.

Reset
REQ-029 On rst low: state FETCH, pc=RESET_PC, all decoded outputs 0, instret=0, instr_done=0, illegal=0, counter 0.
REQ-030 Reset mid-instruction SHALL abandon it without retiring; first fetch after release at RESET_PC.

Configuration
REQ-031 Macro ILLEGAL_TRAP_EN: defined -> unrecognised opcode or REQ-025 illegal fun3 sets illegal=1 in DECODE, enters HALT (imem_req=0, no retire) until reset.
REQ-032 Undefined -> such instructions execute as NOP: instType=1, rd=0, imm=0, retire normally, pc+4; illegal tied 0.

Structure
REQ-033 Shared package core_pkg SHALL hold instType encodings, RV32I opcode constants, fun3 branch codes and state enum.
REQ-034 Immediate extraction SHALL be a combinational sub-module imm_gen (instruction in, format-selected imm out).

Verification
REQ-035 Reset release, imem_valid tied 1, ADDI x1,x0,5 (32'h00500093) -> instType=1, rd=1, imm=5, instr_done at cycle 5, pc=4, instret=1.
REQ-036 BEQ at pc 0x10, imm=+8, alu_flags Z=1 -> next pc 0x18; repeat Z=0 -> 0x14.
REQ-037 JALR x1,4(x2), rs1_data=32'h0000_1003 -> next pc 32'h0000_1006 (bit0 cleared).
REQ-038 imem_valid held low 7 cycles in FETCH -> imem_req stays 1, pc unchanged, no instr_done; retire on 8th-cycle valid.
REQ-039 Opcode 7'b1111111: with ILLEGAL_TRAP_EN -> illegal=1, HALT, instret frozen; without -> NOP, pc+4.
REQ-040 rst asserted during EXEC -> outputs zeroed asynchronously, instret unchanged at 0, fetch resumes at RESET_PC.
